// File: rtl/replica_pkg.sv
// Shared types and default sizing for the replica-exchange scheduler and its command generator.
package replica_pkg;

    typedef enum logic [1:0] {
        NOP  = 2'd0,
        PREV = 2'd1,
        FOLW = 2'd2,
        SELF = 2'd3
    } exchange_command_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        JUDGE = 3'd1,
        ISSUE = 3'd2,
        XFER  = 3'd3,
        DONE  = 3'd4
    } sched_state_t;

    localparam int replica_num     = 32;
    localparam int replica_num_log = $clog2(replica_num);
    localparam int city_div        = 8;
    localparam int city_div_log    = $clog2(city_div);

endpackage

// File: rtl/exchange_cmd_gen.sv
// Turns the accepted-pair vector of a round into one exchange command per replica lane.
module exchange_cmd_gen
    import replica_pkg::*;
#(
    parameter int replica_num = 32
) (
    input  logic [replica_num-2:0] accept_vec,
    input  logic                   parity,
    input  logic                   issue,
    output exchange_command_t      command [replica_num]
);

    for (genvar r = 0; r < replica_num; r++) begin : g_lane
        localparam bit odd = (r % 2) == 1;
        logic folw;
        logic prev;

        // A lane leads its pair only when the pair (r,r+1) belongs to this round's parity.
        if (r < replica_num - 1) begin : g_folw
            assign folw = accept_vec[r] && (odd == parity);
        end else begin : g_no_folw
            assign folw = 1'b0;
        end

        if (r > 0) begin : g_prev
            assign prev = accept_vec[r-1] && (odd != parity);
        end else begin : g_no_prev
            assign prev = 1'b0;
        end

        assign command[r] = !issue ? NOP :
                            folw   ? FOLW :
                            prev   ? PREV : SELF;
    end

endmodule

// File: rtl/exchange_scheduler.sv
// Replica-exchange round sequencer: judges neighbour pairs, issues commands, counts transfer beats.
// Optional per-pair accept statistics are built when EXCHANGE_SCHEDULER_STAT_EN is defined.
module exchange_scheduler
    import replica_pkg::*;
#(
    parameter int replica_num = 32,
    parameter int city_div    = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           ordering_req,
    output logic                           ordering_gnt,
    output logic                           busy,
    output logic                           done,
    output logic                           parity,
    output logic                           judge_req,
    output logic [$clog2(replica_num)-1:0] judge_pair,
    input  logic                           judge_ack,
    input  logic                           judge_accept,
    output exchange_command_t              command [replica_num],
    output logic [replica_num-2:0]         accept_vec,
    input  logic                           xfer_valid,
`ifdef EXCHANGE_SCHEDULER_STAT_EN
    input  logic [$clog2(replica_num)-1:0] stat_addr,
    input  logic                           stat_clear,
    output logic [15:0]                    stat_data,
`endif
    output sched_state_t                   fsm_state
);

    localparam int pair_w = $clog2(replica_num);
    localparam int beat_w = (city_div > 1) ? $clog2(city_div) : 1;
    localparam logic [beat_w-1:0] beat_last = beat_w'(city_div - 1);

    sched_state_t      state;
    sched_state_t      next_state;
    logic              start_pending;
    logic [beat_w-1:0] beat_cnt;
    logic              go;
    logic              last_pair;

    // The ordering port owns the RAMs: a round may only begin once both request and grant are low.
    assign go        = (state == IDLE) && (start || start_pending) && !ordering_req && !ordering_gnt;
    assign last_pair = (int'(judge_pair) + 3) >= replica_num;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (go) next_state = ((int'(parity) + 1) >= replica_num) ? ISSUE : JUDGE;
            JUDGE:   if (judge_ack && last_pair) next_state = ISSUE;
            ISSUE:   next_state = XFER;
            XFER:    if (xfer_valid && (beat_cnt == beat_last)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            parity        <= 1'b0;
            accept_vec    <= '0;
            judge_pair    <= '0;
            beat_cnt      <= '0;
            start_pending <= 1'b0;
            ordering_gnt  <= 1'b0;
        end else begin
            state <= next_state;
            // Grant tracks the request only while no round is running (DONE hands back on exit).
            ordering_gnt <= ((state == IDLE) || (state == DONE)) ? ordering_req : 1'b0;

            if (state == IDLE) begin
                if (go) start_pending <= 1'b0;
                else if (start && (ordering_req || ordering_gnt)) start_pending <= 1'b1;
            end

            if (go) begin
                accept_vec    <= '0;
                judge_pair    <= '0;
                judge_pair[0] <= parity;
            end else if ((state == JUDGE) && judge_ack) begin
                accept_vec[judge_pair] <= judge_accept;
                judge_pair             <= judge_pair + pair_w'(2);
            end

            if (state == ISSUE) begin
                beat_cnt <= '0;
            end else if ((state == XFER) && xfer_valid) begin
                beat_cnt <= (beat_cnt == beat_last) ? '0 : beat_cnt + 1'b1;
            end

            if (state == DONE) parity <= ~parity;
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign judge_req = (state == JUDGE);
    assign fsm_state = state;

    exchange_cmd_gen #(
        .replica_num (replica_num)
    ) u_cmd_gen (
        .accept_vec (accept_vec),
        .parity     (parity),
        .issue      (state == ISSUE),
        .command    (command)
    );

`ifdef EXCHANGE_SCHEDULER_STAT_EN
    logic [15:0] stat_cnt [replica_num-1];

    always_ff @(posedge clk) begin
        if (reset || stat_clear) begin
            for (int i = 0; i < replica_num - 1; i++) stat_cnt[i] <= '0;
        end else if (state == DONE) begin
            for (int i = 0; i < replica_num - 1; i++) begin
                if (accept_vec[i] && (stat_cnt[i] != 16'hFFFF)) stat_cnt[i] <= stat_cnt[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) stat_data <= '0;
        else stat_data <= (int'(stat_addr) < replica_num - 1) ? stat_cnt[stat_addr] : 16'd0;
    end
`endif

endmodule

// File: doc/exchange_scheduler.md
Name: exchange_scheduler

Overview:
- Sequences one replica-exchange round across the chain of exchange datapaths.
- Walks the even or odd neighbour pairs in turn, asks an external Metropolis judge for an accept/reject decision on each pair, then broadcasts one per-replica exchange command (PREV/FOLW/SELF).
- Counts the tour-transfer beats, then reports done.
- Also arbitrates the shared ordering read port against exchange rounds.

Parameters:
- replica_num, 32, number of replicas in the chain (at least 2).
- city_div, 8, transfer beats per tour (words per replica RAM).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle round request.
- ordering_req  in  1  host wants the ordering read port (level).
- ordering_gnt  out  1  ordering port granted; no round runs while high.
- busy  out  1  round in progress (any state except IDLE).
- done  out  1  one-cycle pulse at end of round.
- parity  out  1  pairing used by the current/last round: 0 = pairs (0,1),(2,3)…; 1 = pairs (1,2),(3,4)….
- judge_req  out  1  decision request, held until ack.
- judge_pair  out  $clog2(replica_num)  lower replica index i of the pair (i,i+1).
- judge_ack  in  1  decision valid.
- judge_accept  in  1  1 = swap the pair; sampled with judge_ack.
- command  out  exchange_command_t [replica_num]  per-replica command, NOP except for one cycle.
- accept_vec  out  replica_num-1  bit i = pair (i,i+1) swapped in the last round.
- xfer_valid  in  1  transfer beat, taken from replica 0 out_valid.

Behaviour:
- Reset values:
  - busy=0, done=0, judge_req=0, ordering_gnt=0, parity=0, accept_vec=0.
  - All command lanes NOP; state IDLE; start_pending=0.
- States: IDLE, JUDGE, ISSUE, XFER, DONE.
- IDLE:
  - ordering_req has priority: ordering_gnt goes high the cycle after ordering_req is seen, and drops the cycle after ordering_req falls.
  - A start seen while ordering_gnt or ordering_req is high sets start_pending. The round begins the first IDLE cycle with ordering_req=0 and ordering_gnt=0.
  - Otherwise start moves to JUDGE next cycle.
  - On round entry: clear accept_vec; judge_pair = parity.
- ordering_req during a round is held off: ordering_gnt is asserted only after return to IDLE.
- JUDGE:
  - judge_req=1 with judge_pair stable until judge_ack.
  - On ack: accept_vec[judge_pair] <= judge_accept; judge_pair += 2.
  - If the new judge_pair+1 >= replica_num, go to ISSUE with judge_req low next cycle.
  - Back-to-back acks are allowed, so minimum one cycle per pair.
  - judge_ack outside JUDGE is ignored.
- ISSUE, exactly one cycle, lane r command:
  - FOLW if accept_vec[r] is set and the pair is this parity.
  - PREV if accept_vec[r-1] is set.
  - Otherwise SELF.
  - Next state XFER.
- XFER:
  - Commands back to NOP.
  - Beat counter counts xfer_valid from 0. When it reaches city_div-1 and xfer_valid is high, go to DONE.
  - No timeout.
- DONE:
  - done=1 for one cycle; parity toggles on the same edge; return to IDLE.
- start while busy is ignored and not pending.
- Replica 0 with parity=1, and the top replica when unpaired, always get SELF.
- Reset mid-round: immediate return to reset values. The datapath re-syncs via its own reset.
- Round latency with 0-cycle judge: npairs + 1 (ISSUE) + city_div beats + 1 (DONE), measured from the cycle after start.

Optional Feature:
- Macro EXCHANGE_SCHEDULER_STAT_EN.
- With the macro defined:
  - Adds inputs stat_addr ($clog2(replica_num)) and stat_clear, and output stat_data (16).
  - Per-pair accept counters, 16-bit saturating at 16'hFFFF, increment in DONE for each accept_vec bit.
  - stat_data is registered with 1-cycle read latency.
  - stat_clear zeroes all counters and wins over a same-cycle increment.
- Without the macro: no ports and no counters.

Decomposition:
- replica_pkg holds:
  - exchange_command_t {NOP, PREV, FOLW, SELF}.
  - replica_num, replica_num_log, city_div, city_div_log.
  - sched_state_t enum.
- One sub-module, exchange_cmd_gen: combinational accept_vec + parity + issue -> command array. Kept separate so it can be tested alone.

Test Plan:
- replica_num=4, city_div=4, parity=0, acks immediate with accept=1,0:
  - judge_pair goes 0 then 2.
  - One ISSUE cycle with command = {FOLW,PREV,SELF,SELF}.
  - done pulses after 4 xfer_valid beats; parity becomes 1.
- Second round, parity=1, accept=1 on pair 1:
  - Single judge request with judge_pair=1.
  - command = {SELF,FOLW,PREV,SELF}; accept_vec = 3'b010.
- ordering_req high, then start pulse:
  - No judge_req while ordering_gnt=1.
  - Round begins 1 cycle after ordering_req falls and ordering_gnt drops.
- ordering_req raised mid-XFER:
  - ordering_gnt stays 0 until the cycle after done.
  - The round completes normally.
- Reset asserted during JUDGE with judge_req high:
  - Next cycle judge_req=0, busy=0, parity=0, all NOP.
  - A later start runs from pair 0.
- With EXCHANGE_SCHEDULER_STAT_EN: three rounds accepting pair 0 -> stat_addr=0 returns 3 one cycle later; stat_clear returns 0.
